// File: rtl/game_pkg.sv
// Shared game constants and bullet state encoding.
// Enemies and the VGA mux park on the same off-screen coordinate.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [9:0] PARK_POS = 10'd1023;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bala_t;

  function automatic logic [9:0] spawn_x(
    input logic [9:0] px,
    input logic [9:0] half_w
  );
    return px + half_w;
  endfunction

endpackage

// File: rtl/municao_player_if.sv
// Bullet bus between the player bullet and the enemy blocks.
// Enemies read the position and return their ORed hit pulse.
interface municao_player_if;

  logic [9:0] posX_municao;
  logic [9:0] posY_municao;
  logic       ativo;
  logic       colisao;

  modport master (
    output posX_municao,
    output posY_municao,
    output ativo,
    input  colisao
  );

  modport slave (
    input  posX_municao,
    input  posY_municao,
    input  ativo,
    output colisao
  );

endinterface

// File: rtl/sincroniza_botao.sv
// Two-flop synchroniser plus registered falling-edge one-shot
// for an active-low key.
module sincroniza_botao (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic s1;
  logic s2;
  logic prev;
  logic v1;
  logic v2;
  logic arm;

  // a key held through reset must be released before it can fire
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      v1    <= 1'b0;
      v2    <= 1'b0;
      arm   <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      prev  <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      arm   <= arm | (v2 & s2);
      press <= arm & prev & ~s2;
    end
  end

endmodule

// File: rtl/municao_player.sv
// Player bullet: fire key spawns one bullet that climbs the
// playfield, retires on hit or top exit, then cools down.
module municao_player
  import game_pkg::*;
#(
  parameter int unsigned STEP_DIV       = 250000,
  parameter int unsigned STEP_PIX       = 4,
  parameter int unsigned SPRITE_W       = 24,
  parameter int unsigned COOLDOWN_TICKS = 8,
  parameter logic [9:0]  PARK           = PARK_POS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_fire,
  input  logic [9:0]              posX_player,
  input  logic [9:0]              posY_player,
  municao_player_if.master        bus,
  output logic [7:0]              disparos,
  output logic [7:0]              acertos
);

  localparam int CW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CDW =
    (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(STEP_DIV - 1);
  localparam logic [CDW-1:0] CD_END =
    CDW'(COOLDOWN_TICKS);
  localparam logic [CDW-1:0] CD_LAST =
    CDW'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
  localparam logic [9:0] DY     = 10'(STEP_PIX);
  localparam logic [9:0] HALF_W = 10'(SPRITE_W / 2);

  logic press;

  sincroniza_botao u_sync (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_fire),
    .press (press)
  );

  bala_t          estado;
  bala_t          estado_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [CDW-1:0] cd_cnt;
  logic [CDW-1:0] cd_cnt_n;
  logic [9:0]     pos_x;
  logic [9:0]     pos_x_n;
  logic [9:0]     pos_y;
  logic [9:0]     pos_y_n;
  logic           ativo_q;
  logic           ativo_n;
  logic [7:0]     disp_n;
  logic [7:0]     hit_n;
  logic           tick;
  logic           cd_wrap;

  assign tick    = (cnt == CNT_LAST);
  assign cd_wrap = (COOLDOWN_TICKS > 0) && (cd_cnt == CD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado   <= IDLE;
      cnt      <= '0;
      cd_cnt   <= '0;
      pos_x    <= PARK;
      pos_y    <= PARK;
      ativo_q  <= 1'b0;
      disparos <= '0;
      acertos  <= '0;
    end else begin
      estado   <= estado_n;
      cnt      <= cnt_n;
      cd_cnt   <= cd_cnt_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      ativo_q  <= ativo_n;
      disparos <= disp_n;
      acertos  <= hit_n;
    end
  end

  always_comb begin
    estado_n = estado;
    cnt_n    = tick ? '0 : cnt + 1'b1;
    cd_cnt_n = cd_cnt;
    pos_x_n  = pos_x;
    pos_y_n  = pos_y;
    ativo_n  = ativo_q;
    disp_n   = disparos;
    hit_n    = acertos;
    unique case (estado)
      IDLE: begin
        cnt_n = '0;
        if (press) begin
          estado_n = FLYING;
          pos_x_n  = spawn_x(posX_player, HALF_W);
          pos_y_n  = posY_player;
          ativo_n  = 1'b1;
          disp_n   = disparos + 1'b1;
        end
      end
      FLYING: begin
        if (bus.colisao) begin
          estado_n = COOLDOWN;
          pos_x_n  = PARK;
          pos_y_n  = PARK;
          ativo_n  = 1'b0;
          cd_cnt_n = '0;
          hit_n    = acertos + 1'b1;
        end else if (tick) begin
          if (pos_y < DY) begin
            estado_n = COOLDOWN;
            pos_x_n  = PARK;
            pos_y_n  = PARK;
            ativo_n  = 1'b0;
            cd_cnt_n = '0;
          end else begin
            pos_y_n = pos_y - DY;
          end
        end
      end
      COOLDOWN: begin
        if (cd_cnt == CD_END) begin
          estado_n = IDLE;
        end else if (tick) begin
          cd_cnt_n = cd_cnt + 1'b1;
          if (cd_wrap) begin
            estado_n = IDLE;
          end
        end
      end
      default: begin
        estado_n = IDLE;
      end
    endcase
  end

  assign bus.posX_municao = pos_x;
  assign bus.posY_municao = pos_y;
  assign bus.ativo        = ativo_q;

endmodule

// File: tb/tb_municao_player.sv
// Directed bench for municao_player: two instances, one with the
// slow test timing and one at STEP_DIV=1 for counter wrap.
module tb_municao_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire_a;
  logic       fire_b;
  logic [9:0] px_a;
  logic [9:0] py_a;
  logic [9:0] px_b;
  logic [9:0] py_b;
  logic [7:0] disp_a;
  logic [7:0] hit_a;
  logic [7:0] disp_b;
  logic [7:0] hit_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  municao_player_if bus_a ();
  municao_player_if bus_b ();

  municao_player #(
    .STEP_DIV       (4),
    .STEP_PIX       (4),
    .SPRITE_W       (24),
    .COOLDOWN_TICKS (2)
  ) u_a (
    .clk         (clk),
    .reset       (reset),
    .btn_fire    (fire_a),
    .posX_player (px_a),
    .posY_player (py_a),
    .bus         (bus_a),
    .disparos    (disp_a),
    .acertos     (hit_a)
  );

  municao_player #(
    .STEP_DIV       (1),
    .STEP_PIX       (4),
    .SPRITE_W       (24),
    .COOLDOWN_TICKS (0)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .btn_fire    (fire_b),
    .posX_player (px_b),
    .posY_player (py_b),
    .bus         (bus_b),
    .disparos    (disp_b),
    .acertos     (hit_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    fire_a        = 1'b1;
    fire_b        = 1'b1;
    px_a          = 10'd100;
    py_a          = 10'd400;
    px_b          = 10'd200;
    py_b          = 10'd400;
    bus_a.colisao = 1'b0;
    bus_b.colisao = 1'b0;
    step(2);
    chk("rst_x", bus_a.posX_municao, 1023);
    chk("rst_y", bus_a.posY_municao, 1023);
    chk("rst_ativo", bus_a.ativo, 0);
    chk("rst_disp", disp_a, 0);
    chk("rst_hit", hit_a, 0);
    reset = 1'b1;
    step(5);

    // spawn: ativo exactly 3 edges after first low sample
    fire_a = 1'b0;
    step(3);
    chk("spawn_early", bus_a.ativo, 0);
    step(1);
    chk("spawn_ativo", bus_a.ativo, 1);
    chk("spawn_x", bus_a.posX_municao, 112);
    chk("spawn_y", bus_a.posY_municao, 400);
    chk("spawn_disp", disp_a, 1);
    step(3);
    chk("pre_step_y", bus_a.posY_municao, 400);
    step(1);
    chk("step1_y", bus_a.posY_municao, 396);
    step(12);
    chk("step4_y", bus_a.posY_municao, 384);

    // hit coincident with a tick
    step(3);
    bus_a.colisao = 1'b1;
    step(1);
    bus_a.colisao = 1'b0;
    chk("hit_x", bus_a.posX_municao, 1023);
    chk("hit_y", bus_a.posY_municao, 1023);
    chk("hit_ativo", bus_a.ativo, 0);
    chk("hit_cnt", hit_a, 1);
    chk("hit_state", int'(u_a.estado), 2);
    chk("held_disp", disp_a, 1);

    // re-press during cooldown is dropped
    fire_a = 1'b1;
    step(2);
    fire_a = 1'b0;
    step(8);
    chk("busy_ativo", bus_a.ativo, 0);
    chk("busy_disp", disp_a, 1);

    // press from IDLE fires again
    fire_a = 1'b1;
    step(4);
    fire_a = 1'b0;
    step(4);
    chk("refire_ativo", bus_a.ativo, 1);
    chk("refire_disp", disp_a, 2);

    // reset mid-flight with key held
    step(20);
    chk("fly_y380", bus_a.posY_municao, 380);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mrst_x", bus_a.posX_municao, 1023);
    chk("mrst_y", bus_a.posY_municao, 1023);
    chk("mrst_ativo", bus_a.ativo, 0);
    chk("mrst_disp", disp_a, 0);
    step(20);
    chk("held_rst_ativo", bus_a.ativo, 0);
    chk("held_rst_disp", disp_a, 0);
    fire_a = 1'b1;
    step(4);
    fire_a = 1'b0;
    step(4);
    chk("post_rst_ativo", bus_a.ativo, 1);
    chk("post_rst_disp", disp_a, 1);
    bus_a.colisao = 1'b1;
    step(1);
    bus_a.colisao = 1'b0;
    step(10);

    // top exit
    fire_a = 1'b1;
    step(4);
    py_a   = 10'd6;
    fire_a = 1'b0;
    step(4);
    chk("top_spawn_y", bus_a.posY_municao, 6);
    chk("top_spawn_disp", disp_a, 2);
    step(4);
    chk("top_y2", bus_a.posY_municao, 2);
    step(3);
    chk("top_still", bus_a.ativo, 1);
    step(1);
    chk("top_x", bus_a.posX_municao, 1023);
    chk("top_y", bus_a.posY_municao, 1023);
    chk("top_ativo", bus_a.ativo, 0);
    chk("top_hit", hit_a, 1);
    step(7);
    chk("top_cd_wait", int'(u_a.estado), 2);
    step(1);
    chk("top_cd_done", int'(u_a.estado), 0);

    // counter wrap on the fast instance
    for (int i = 0; i < 256; i++) begin
      fire_b = 1'b0;
      step(4);
      if (i == 0) chk("b_spawn", bus_b.ativo, 1);
      bus_b.colisao = 1'b1;
      step(1);
      bus_b.colisao = 1'b0;
      fire_b = 1'b1;
      step(3);
      if (i == 254) begin
        chk("b_disp255", disp_b, 255);
        chk("b_hit255", hit_b, 255);
      end
    end
    chk("b_disp_wrap", disp_b, 0);
    chk("b_hit_wrap", hit_b, 0);
    bus_b.colisao = 1'b1;
    step(1);
    bus_b.colisao = 1'b0;
    step(2);
    chk("b_idle_hit", hit_b, 0);
    chk("b_idle_ativo", bus_b.ativo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/municao_player.md
Name: municao_player

Overview:
- Player-bullet controller. Sits directly upstream of each enemy block.
- Drives the bullet position that every enemy tests for collision, and consumes the enemies' ORed colisao pulse to retire the bullet.
- Converts a fire-button press into a single bullet that climbs the 640x480 playfield at a fixed step rate, followed by a cooldown.
- While no bullet is in flight, the position is parked off-screen so no enemy can register a false hit.

Parameters:
- STEP_DIV, 250000: clock cycles per movement step (50 MHz gives 200 steps/s); legal values ≥1.
- STEP_PIX, 4: pixels the bullet rises per step; legal values 1..15.
- SPRITE_W, 24: player sprite width; spawn X = player X + SPRITE_W/2.
- COOLDOWN_TICKS, 8: steps to wait after a bullet retires before firing is re-enabled; 0 is legal.
- PARK, 10'd1023: X and Y value output when no bullet is in flight.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- btn_fire  in  1  raw fire key, active-low, asynchronous to clk
- posX_player  in  10  player sprite left X
- posY_player  in  10  player sprite top Y
- colisao  in  1  OR of all enemy colisao outputs; 1-cycle hit pulse
- posX_municao  out  10  bullet X (PARK when inactive)
- posY_municao  out  10  bullet Y (PARK when inactive)
- ativo  out  1  bullet in flight
- disparos  out  8  shots fired; wraps 255→0
- acertos  out  8  hits scored; wraps 255→0

Behaviour:
- Reset (reset==0 at a rising edge):
  - Outputs: posX/posY_municao=PARK, ativo=0, disparos=0, acertos=0.
  - State=IDLE; step counter=0; cooldown counter=0.
  - Both synchroniser flops and the edge-detect register are loaded with 1 (released key).
  - Reset wins over every other event, including mid-flight and mid-cooldown.
- Button path:
  - Two-flop synchroniser, then a previous-value register.
  - press = (prev==1 && sync==0).
  - A 1→0 transition on btn_fire first sampled at edge k produces press during the cycle after edge k+2.
  - State changes to FLYING at edge k+3 (ativo=1 visible after edge k+3).
  - Holding the key produces exactly one press; a new press requires release and re-press.
- States: IDLE, FLYING, COOLDOWN.
- IDLE:
  - press → FLYING.
  - Spawn: posX_municao = posX_player + SPRITE_W/2, computed 10-bit; wrap is not checked, as player X is ≤ 616.
  - Spawn: posY_municao = posY_player.
  - On spawn: ativo=1, step counter=0, disparos+=1.
  - colisao is ignored in IDLE.
- FLYING:
  - Step counter counts 0..STEP_DIV-1; tick = (counter==STEP_DIV-1); counter wraps to 0 on tick.
  - Priority order:
    1. colisao=1 → COOLDOWN, park, ativo=0, acertos+=1, cooldown counter=0. A tick in the same cycle is discarded.
    2. Tick with posY_municao < STEP_PIX → COOLDOWN, park, ativo=0; acertos unchanged.
    3. Tick otherwise → posY_municao -= STEP_PIX. posX_municao is constant during flight.
  - press during FLYING is discarded, not queued.
- COOLDOWN:
  - Step counter keeps running.
  - Each tick increments the cooldown counter.
  - When the cooldown counter reaches COOLDOWN_TICKS → IDLE.
  - COOLDOWN_TICKS=0 → IDLE on the next edge.
  - press and colisao are discarded.
- Position outputs are registered; no combinational path exists from any input to any output.
- First movement occurs STEP_DIV cycles after the spawn edge.

Decomposition:
- Shared package (game_pkg):
  - Constants: SCREEN_W=640, SCREEN_H=480, PARK_POS=10'd1023.
  - Bullet state encoding: IDLE=2'd0, FLYING=2'd1, COOLDOWN=2'd2.
  - Enemies and the VGA mux use the same PARK_POS constant.
- One sub-module: sincroniza_botao.
  - Function: 2-flop synchroniser plus falling-edge one-shot.
  - Ports: clk, reset, btn_n in, press out.
  - Reused later by the player movement keys.

Test Plan (STEP_DIV=4, STEP_PIX=4, COOLDOWN_TICKS=2, SPRITE_W=24 unless noted):
- Spawn: posX_player=100, posY_player=400, btn_fire 1→0 → ativo=1 exactly 3 edges after the first low sample; posX=112, posY=400, disparos=1. After 16 more cycles, posY=384.
- Top exit: spawn with posY_player=6 → posY=2 after 4 cycles. At the next tick → posX=posY=1023, ativo=0. IDLE is re-entered after 2 further ticks (8 cycles); acertos=0.
- Hit vs tick: colisao=1 in the same cycle as a tick → park, no Y decrement, acertos=1, state=COOLDOWN.
- Held key and busy press: btn_fire held low for 200 cycles → disparos=1. A release and re-press during FLYING or COOLDOWN → no new shot. A press after returning to IDLE → disparos=2.
- Reset mid-flight: reset=0 for one edge while posY=380 → posX=posY=1023, ativo=0, disparos=0. Holding btn_fire low through reset release gives no shot until the key is released and pressed again.
- Wrap: 256 fire/hit cycles with STEP_DIV=1, COOLDOWN_TICKS=0 → disparos=0 and acertos=0 after wrap; colisao pulses in IDLE leave acertos unchanged.
